relu_maxpool_stage: RTL and testbench

//  Streaming ReLU + 2x2/stride-2 max-pool + requantiser sitting directly downstream of the

---
 rtl/relu_maxpool_stage.sv | 194 +++++++++++++++++++
 tb/tb_relu_maxpool_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stage.sv
// Streaming ReLU + 2x2/stride-2 max-pool + requantiser for conv-output pixels (CH lanes in parallel).
// Optional feature: define REQUANT_ROUND_EN for round-half-up requantisation instead of truncation.
module relu_maxpool_stage #(
    parameter int CH         = 6,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int MAX_CONV_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_async_i,
    input  logic                  start_i,
    input  logic [5:0]            cfg_conv_w_i,
    input  logic [5:0]            cfg_conv_h_i,
    input  logic [4:0]            cfg_shift_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CH*ACC_W-1:0]   in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CH*OUT_W-1:0]   out_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int LB_D  = MAX_CONV_W / 2;
    localparam int LB_AW = $clog2(LB_D);
    localparam logic [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic [5:0]            r_conv_w;
    logic [5:0]            r_conv_h;
    logic [4:0]            r_shift;
    logic [5:0]            r_col;
    logic [5:0]            r_row;
    logic [CH*ACC_W-1:0]   r_hold;
    logic [CH*ACC_W-1:0]   r_lbuf [LB_D];
    logic                  r_out_valid;
    logic [CH*OUT_W-1:0]   r_out_data;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_last_in;
    logic                  w_empty_frame;
    logic                  w_emit;
    logic [LB_AW-1:0]      w_lidx;
    logic [CH*ACC_W-1:0]   w_lbuf_rd;
    logic [CH*ACC_W-1:0]   w_hmax;
    logic [CH*OUT_W-1:0]   w_pool_q;

    function automatic logic [ACC_W-1:0] smax(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // ReLU, right-shift and clamp to the positive OUT_W range; headroom bit absorbs the rounding add
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] v, input logic [4:0] sh);
        logic [ACC_W:0] r;
        logic [ACC_W:0] q;
        r = v[ACC_W-1] ? {(ACC_W+1){1'b0}} : {1'b0, v};
`ifdef REQUANT_ROUND_EN
        if (sh != 5'd0) begin
            q = (r + ({{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1))) >> sh;
        end else begin
            q = r;
        end
`else
        q = r >> sh;
`endif
        return (q > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : q[OUT_W-1:0];
    endfunction

    assign w_in_ready    = (r_state == S_RUN) && (!r_out_valid || out_ready_i);
    assign w_accept      = w_in_ready && in_valid_i;
    assign w_last_col    = (r_col == (r_conv_w - 6'd1));
    assign w_last_row    = (r_row == (r_conv_h - 6'd1));
    assign w_last_in     = w_accept && w_last_col && w_last_row;
    assign w_empty_frame = (r_conv_w == 6'd0) || (r_conv_h == 6'd0);
    assign w_emit        = r_row[0] && r_col[0];
    assign w_lidx        = r_col[LB_AW:1];
    assign w_lbuf_rd     = r_lbuf[w_lidx];

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    // State register plus registered status outputs decoded from the next state
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; an empty frame (zero width or height) needs no inputs
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start_i ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = (w_empty_frame || w_last_in) ? S_FLUSH : S_RUN;
            S_FLUSH: w_state_nxt = r_out_valid ? S_FLUSH : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN, S_FLUSH: w_busy_nxt = 1'b1;
            S_DONE:         w_done_nxt = 1'b1;
            default:        w_busy_nxt = 1'b0;
        endcase
    end

    // Per-lane horizontal max, vertical max against the line buffer, then requantise
    always_comb begin
        w_hmax   = '0;
        w_pool_q = '0;
        for (int c = 0; c < CH; c++) begin
            w_hmax[c*ACC_W +: ACC_W] = smax(r_hold[c*ACC_W +: ACC_W], in_data_i[c*ACC_W +: ACC_W]);
        end
        for (int c = 0; c < CH; c++) begin
            w_pool_q[c*OUT_W +: OUT_W] = requant(smax(w_lbuf_rd[c*ACC_W +: ACC_W], w_hmax[c*ACC_W +: ACC_W]), r_shift);
        end
    end

    // Config latch, scan counters, horizontal hold and output register
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            r_conv_w    <= 6'd0;
            r_conv_h    <= 6'd0;
            r_shift     <= 5'd0;
            r_col       <= 6'd0;
            r_row       <= 6'd0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_conv_w <= cfg_conv_w_i;
                r_conv_h <= cfg_conv_h_i;
                r_shift  <= cfg_shift_i;
                r_col    <= 6'd0;
                r_row    <= 6'd0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_col <= 6'd0;
                    r_row <= r_row + 6'd1;
                end else begin
                    r_col <= r_col + 6'd1;
                end
                if (!r_col[0]) begin
                    r_hold <= in_data_i;
                end
            end
            // Accept is only possible while the output reg is empty or draining this cycle
            if (w_accept && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pool_q;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Line buffer: even rows store horizontal maxima that the following odd row reads back
    always_ff @(posedge clk_i) begin
        if (w_accept && !r_row[0] && r_col[0]) begin
            r_lbuf[w_lidx] <= w_hmax;
        end
    end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed self-checking bench for relu_maxpool_stage (reset, pooling, ReLU, saturation, odd dims, stalls).
module tb_relu_maxpool_stage;

    localparam int CH = 6;

    logic           clk_i = 1'b0;
    logic           rst_async_i = 1'b1;
    logic           start_i = 1'b0;
    logic [5:0]     cfg_conv_w_i = '0;
    logic [5:0]     cfg_conv_h_i = '0;
    logic [4:0]     cfg_shift_i = '0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [191:0]   in_data_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic [47:0]    out_data_o;
    logic           busy_o;
    logic           done_o;

    int             n_cmp = 0;
    int             n_fail = 0;
    logic [191:0]   frame_mem [0:575];
    logic [47:0]    exp_q [$];

    relu_maxpool_stage dut (
        .clk_i(clk_i), .rst_async_i(rst_async_i), .start_i(start_i),
        .cfg_conv_w_i(cfg_conv_w_i), .cfg_conv_h_i(cfg_conv_h_i), .cfg_shift_i(cfg_shift_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [191:0] pix0(input int v0, input int others);
        logic [191:0] p;
        for (int l = 0; l < CH; l++) p[l*32 +: 32] = (l == 0) ? 32'(v0) : 32'(others);
        return p;
    endfunction

    function automatic logic [7:0] ref_lane(input int a, input int b, input int c, input int d, input int sh);
        longint m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 0) m = 0;
`ifdef REQUANT_ROUND_EN
        if (sh > 0) m = (m + (longint'(1) << (sh - 1))) >>> sh;
`else
        m = m >>> sh;
`endif
        if (m > 127) m = 127;
        return 8'(m);
    endfunction

    // Runs one frame from frame_mem, optionally with random stalls, and checks it against exp_q
    task automatic run_frame(input int w, input int h, input int sh, input bit stall, input string tag);
        int idx = 0;
        int cyc = 0;
        int ndone = 0;
        bit held = 0;
        bit acc_in;
        logic [47:0] held_d = '0;
        logic [47:0] got_q [$];
        start_i = 1'b1;
        cfg_conv_w_i = 6'(w);
        cfg_conv_h_i = 6'(h);
        cfg_shift_i = 5'(sh);
        step();
        start_i = 1'b0;
        check({tag, " busy"}, 64'(busy_o), 64'd1);
        while (ndone == 0 && cyc < 20000) begin
            in_valid_i = (idx < w*h) && (!stall || $urandom_range(0, 3) != 0);
            in_data_i = (idx < w*h) ? frame_mem[idx] : '0;
            out_ready_i = !stall || ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                check({tag, " hold_valid"}, 64'(out_valid_o), 64'd1);
                check({tag, " hold_data"}, 64'(out_data_o), 64'(held_d));
            end
            held = out_valid_o && !out_ready_i;
            held_d = out_data_o;
            acc_in = in_valid_i && in_ready_o;
            if (out_valid_o && out_ready_i) got_q.push_back(out_data_o);
            step();
            if (acc_in) idx++;
            cyc++;
            if (done_o) ndone++;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done_o) ndone++;
        end
        check({tag, " inputs"}, 64'(idx), 64'(w*h));
        check({tag, " done_cnt"}, 64'(ndone), 64'd1);
        check({tag, " busy_end"}, 64'(busy_o), 64'd0);
        check({tag, " out_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check({tag, $sformatf(" out%0d", k)}, 64'(got_q[k]), 64'(exp_q[k]));
        exp_q.delete();
    endtask

    initial begin
        int sh4;
        int base;
        repeat (2) step();
        rst_async_i = 1'b0;
        step();
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_ready", 64'(in_ready_o), 64'd0);

        // 1: abort a 4x4 frame with a pooled pixel pending
        for (int i = 0; i < 16; i++) frame_mem[i] = pix0(i, -1);
        start_i = 1'b1; cfg_conv_w_i = 6'd4; cfg_conv_h_i = 6'd4; cfg_shift_i = 5'd0;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid_i = 1'b1; out_ready_i = 1'b0; in_data_i = frame_mem[i];
            step();
        end
        in_valid_i = 1'b0;
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        check("pre_rst_data", 64'(out_data_o), 64'd5);
        #2 rst_async_i = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        step();
        rst_async_i = 1'b0;
        step();
        check("post_rst_busy", 64'(busy_o), 64'd0);

        // 2: 4x4, lane0 = row*4+col, other lanes negative
        exp_q.push_back(48'd5); exp_q.push_back(48'd7);
        exp_q.push_back(48'd13); exp_q.push_back(48'd15);
        run_frame(4, 4, 0, 1'b0, "t2");

        // 3: all negative 4x2
        for (int i = 0; i < 8; i++) frame_mem[i] = pix0(-100, -100);
        exp_q.push_back(48'd0); exp_q.push_back(48'd0);
        run_frame(4, 2, 0, 1'b0, "t3");

        // 4: saturation and requant shift on a 2x2 of 1000
        for (int i = 0; i < 4; i++) frame_mem[i] = pix0(1000, 1000);
        exp_q.push_back({6{8'd127}});
        run_frame(2, 2, 2, 1'b0, "t4a");
`ifdef REQUANT_ROUND_EN
        sh4 = 63;
`else
        sh4 = 62;
`endif
        exp_q.push_back({6{8'(sh4)}});
        run_frame(2, 2, 4, 1'b0, "t4b");

        // 5: odd dims 5x3, lane0 = row*5+col
        for (int i = 0; i < 15; i++) frame_mem[i] = pix0(i, -7);
        exp_q.push_back(48'd6); exp_q.push_back(48'd8);
        run_frame(5, 3, 0, 1'b0, "t5");

        // 6: 24x24 random frame with random stalls, golden pooled outputs
        for (int i = 0; i < 576; i++)
            for (int l = 0; l < CH; l++)
                frame_mem[i][l*32 +: 32] = 32'($urandom_range(0, 6000)) - 32'd3000;
        for (int pr = 0; pr < 12; pr++) begin
            for (int pc = 0; pc < 12; pc++) begin
                logic [47:0] e;
                base = (2*pr)*24 + 2*pc;
                for (int l = 0; l < CH; l++)
                    e[l*8 +: 8] = ref_lane($signed(frame_mem[base][l*32 +: 32]),
                                           $signed(frame_mem[base+1][l*32 +: 32]),
                                           $signed(frame_mem[base+24][l*32 +: 32]),
                                           $signed(frame_mem[base+25][l*32 +: 32]), 3);
                exp_q.push_back(e);
            end
        end
        run_frame(24, 24, 3, 1'b1, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
